// File: rtl/ps2_sender.sv
// PS/2 device-side sender: turns key events into E0/F0/code frames.
// Optional E0 prefix for extended keys is enabled by PS2_SENDER_EXT_EN.
module ps2_sender #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_BITS    = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_release,
  input  logic       key_ext,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       frame_done
);

  localparam int BT = 2 * HALF_PERIOD;
  localparam int CW = $clog2(BT);
  localparam int GT = (GAP_BITS > 0) ? GAP_BITS * BT : 1;
  localparam int GW = (GT > 1) ? $clog2(GT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(BT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_PERIOD);
  localparam logic [GW-1:0] GAP_LAST = GW'(GT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gap, gap_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    cur, cur_n;
  logic [7:0]    code, code_n;
  logic          need_f0, need_f0_n;
  logic          need_code, need_code_n;
  logic          clk_n, data_n, done_n, ready_n;
  logic          accept, bit_end, load_next, ext_eff;

`ifdef PS2_SENDER_EXT_EN
  assign ext_eff = key_ext;
`else
  logic unused_key_ext;
  assign unused_key_ext = key_ext;
  assign ext_eff = 1'b0;
`endif

  assign accept  = key_valid & key_ready;
  assign bit_end = (cnt == CNT_LAST);

  // State, counters and byte sequencing registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      cnt       <= '0;
      gap       <= '0;
      bit_idx   <= '0;
      cur       <= '0;
      code      <= '0;
      need_f0   <= 1'b0;
      need_code <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap       <= gap_n;
      bit_idx   <= bit_idx_n;
      cur       <= cur_n;
      code      <= code_n;
      need_f0   <= need_f0_n;
      need_code <= need_code_n;
    end
  end

  // Registered line outputs so ps2_clk/ps2_data never glitch
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
      key_ready  <= 1'b0;
    end else begin
      ps2_clk    <= clk_n;
      ps2_data   <= data_n;
      frame_done <= done_n;
      key_ready  <= ready_n;
    end
  end

  // Next-state: bit timing, byte framing and multi-byte sequencing
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    gap_n       = gap;
    bit_idx_n   = bit_idx;
    cur_n       = cur;
    code_n      = code;
    need_f0_n   = need_f0;
    need_code_n = need_code;
    load_next   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n     = START;
          cnt_n       = '0;
          code_n      = key_code;
          need_f0_n   = ext_eff & key_release;
          need_code_n = ext_eff | key_release;
          if (ext_eff)
            cur_n = 8'hE0;
          else if (key_release)
            cur_n = 8'hF0;
          else
            cur_n = key_code;
        end
      end
      START: begin
        cnt_n = bit_end ? '0 : cnt + 1'b1;
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        cnt_n = bit_end ? '0 : cnt + 1'b1;
        if (bit_end) begin
          if (bit_idx == 3'd7)
            state_n = PARITY;
          else
            bit_idx_n = bit_idx + 1'b1;
        end
      end
      PARITY: begin
        cnt_n = bit_end ? '0 : cnt + 1'b1;
        if (bit_end)
          state_n = STOP;
      end
      STOP: begin
        cnt_n = bit_end ? '0 : cnt + 1'b1;
        if (bit_end) begin
          if (GAP_BITS > 0) begin
            state_n = GAP;
            gap_n   = '0;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      GAP: begin
        gap_n = gap + 1'b1;
        if (gap == GAP_LAST)
          load_next = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (load_next) begin
      cnt_n = '0;
      gap_n = '0;
      if (need_f0) begin
        state_n   = START;
        cur_n     = 8'hF0;
        need_f0_n = 1'b0;
      end else if (need_code) begin
        state_n     = START;
        cur_n       = code;
        need_code_n = 1'b0;
      end else begin
        state_n = IDLE;
      end
    end
  end

  // Output values for the cycle being entered
  always_comb begin
    clk_n   = 1'b1;
    data_n  = 1'b1;
    done_n  = 1'b0;
    ready_n = (state_n == IDLE);
    case (state_n)
      START: begin
        clk_n  = (cnt_n < CNT_HALF);
        data_n = 1'b0;
      end
      DATA: begin
        clk_n  = (cnt_n < CNT_HALF);
        data_n = cur_n[bit_idx_n];
      end
      PARITY: begin
        clk_n  = (cnt_n < CNT_HALF);
        data_n = ~^cur_n;
      end
      STOP: begin
        clk_n  = (cnt_n < CNT_HALF);
        data_n = 1'b1;
        done_n = (cnt_n == CNT_LAST);
      end
      default: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_sender.sv
// Randomized self-checking bench for ps2_sender.
// Reference: byte list from event rules, frames from PS/2 framing.
module tb_ps2_sender;

  localparam int HP   = 4;
  localparam int GAPB = 2;
  localparam int BT   = 2 * HP;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_release = 1'b0;
  logic       key_ext = 1'b0;
  logic       key_ready, ps2_clk, ps2_data, frame_done;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int nfd = 0;
  int nbits = 0;
  logic prev_clk = 1'b1;
  logic prev_data = 1'b1;
  logic [10:0] sh = '0;
  logic [10:0] frames[$];

  ps2_sender #(.HALF_PERIOD(HP), .GAP_BITS(GAPB)) dut (
    .clk(clk),
    .clrn(clrn),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_release(key_release),
    .key_ext(key_ext),
    .key_ready(key_ready),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= clrn ? cyc + 1 : 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) == 0;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Host-side receiver: sample data on ps2_clk falling edges
  always @(negedge clk) begin
    if (!clrn) begin
      nbits = 0;
      prev_clk = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (ps2_data !== prev_data)
        check("data_change_clk_high", ps2_clk, 1);
      if (prev_clk && !ps2_clk) begin
        sh[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          frames.push_back(sh);
          nbits = 0;
        end
      end
      if (frame_done) nfd++;
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (key_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic send(logic [7:0] c, logic rel, logic ext, bit hold);
    logic [7:0] exp[$];
    int t, n0, f0, n;
    bit ok;
    exp = {};
`ifdef PS2_SENDER_EXT_EN
    if (ext) exp.push_back(8'hE0);
`endif
    if (rel) exp.push_back(8'hF0);
    exp.push_back(c);
    n = exp.size();
    wait_ready(ok);
    if (!ok) return;
    key_code = c;
    key_release = rel;
    key_ext = ext;
    key_valid = 1'b1;
    t = cyc;
    n0 = frames.size();
    f0 = nfd;
    check("idle_data", ps2_data, 1);
    @(negedge clk);
    check("start_bit", ps2_data, 0);
    check("ready_low", key_ready, 0);
    if (hold) begin
      key_code = ~c;
      key_release = ~rel;
    end else begin
      key_valid = 1'b0;
    end
    repeat (HP - 1) @(negedge clk);
    check("clk_high", ps2_clk, 1);
    @(negedge clk);
    check("clk_fall", ps2_clk, 0);
    wait_ready(ok);
    key_valid = 1'b0;
    if (!ok) return;
    check("ready_cycle", cyc - t, 1 + n * (11 + GAPB) * BT);
    check("nframes", frames.size() - n0, n);
    check("ndone", nfd - f0, n);
    for (int i = 0; i < n && n0 + i < frames.size(); i++)
      check("frame", frames[n0 + i], frame_of(exp[i]));
  endtask

  task automatic reset_mid();
    int t, n0, f0;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    key_code = 8'hA5;
    key_release = 1'b0;
    key_ext = 1'b0;
    key_valid = 1'b1;
    t = cyc;
    n0 = frames.size();
    f0 = nfd;
    @(negedge clk);
    key_valid = 1'b0;
    while (cyc < t + 1 + BT * 5 + 5) @(negedge clk);
    check("pre_rst_clk", ps2_clk, 0);
    #2 clrn = 1'b0;
    #1;
    check("rst_clk", ps2_clk, 1);
    check("rst_data", ps2_data, 1);
    check("rst_ready", key_ready, 0);
    check("rst_done", frame_done, 0);
    @(negedge clk);
    #2 clrn = 1'b1;
    repeat (150) @(negedge clk);
    check("rst_nframes", frames.size() - n0, 0);
    check("rst_ndone", nfd - f0, 0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("reset_clk", ps2_clk, 1);
    check("reset_data", ps2_data, 1);
    check("reset_ready", key_ready, 0);
    check("reset_done", frame_done, 0);
    clrn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", key_ready, 1);
    while (cyc < 10) @(negedge clk);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'h1C, 1'b1, 1'b0, 1'b0);
    send(8'h75, 1'b1, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    n0 = frames.size();
    repeat (200) @(negedge clk);
    check("hold_single_event", frames.size() - n0, 0);
    reset_mid();
    send(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_sender.md
PS2_SENDER -- requirements
Module: ps2_sender

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4, clk cycles per ps2_clk high or low phase (legal values ≥ 2).
REQ-002 SHALL have parameter GAP_BITS, default 2, idle bit-times inserted after every byte.
REQ-003 SHALL have port clk, input, 1 bit, system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port clrn, input, 1 bit, asynchronous, active-low reset.
REQ-005 SHALL have port key_valid, input, 1 bit, request to send one key event.
REQ-006 SHALL have port key_code, input, 8 bits, scancode.
REQ-007 SHALL have port key_release, input, 1 bit; 1 means a break event, sent as F0 followed by the code.
REQ-008 SHALL have port key_ext, input, 1 bit, extended-key flag (see Configuration).
REQ-009 SHALL have port key_ready, output, 1 bit; high means a request is accepted this cycle.
REQ-010 SHALL have port ps2_clk, output, 1 bit, generated PS/2 clock; idles high.
REQ-011 SHALL have port ps2_data, output, 1 bit, PS/2 data; idles high.
REQ-012 SHALL have port frame_done, output, 1 bit; pulses for one cycle per completed byte.

Function
REQ-013 SHALL accept a request in any cycle where key_valid=1 and key_ready=1, capturing key_code, key_release and key_ext.
REQ-014 SHALL drive key_ready=1 only in state IDLE, and hold it 0 from the cycle after acceptance until the last byte's gap ends.
REQ-015 SHALL ignore key_valid while key_ready=0; there is no queue, so those requests are dropped.
REQ-016 SHALL send the byte sequence [E0 if extended] [F0 if key_release] key_code, in that order.
REQ-017 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP, GAP:
  - IDLE→START on accept;
  - START→DATA after 1 bit-time;
  - DATA→PARITY after 8 bit-times;
  - PARITY→STOP after 1 bit-time;
  - STOP→GAP after 1 bit-time;
  - GAP→START if more bytes remain, else GAP→IDLE.
REQ-018 SHALL frame each byte as 11 bits:
  - start bit = 0;
  - 8 data bits, LSB first;
  - odd parity bit (total ones in data plus parity is odd);
  - stop bit = 1.
REQ-019 SHALL make one bit-time 2*HALF_PERIOD cycles: ps2_clk high for the first HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
REQ-020 SHALL change ps2_data only on the first cycle of a bit-time, while ps2_clk is high, so the host samples on the falling edge.
REQ-021 SHALL meet this timing for acceptance at cycle T:
  - ps2_data=0 (start bit) from cycle T+1;
  - first ps2_clk falling edge at T+1+HALF_PERIOD;
  - bit k begins at T+1+2*HALF_PERIOD*k.
REQ-022 SHALL hold ps2_clk=1 and ps2_data=1 during GAP for GAP_BITS*2*HALF_PERIOD cycles.
REQ-023 SHALL assert frame_done on the cycle the STOP bit-time ends.
REQ-024 SHALL return key_ready=1 on the cycle after the final GAP cycle; with the default parameters, a single-byte event is therefore accepted again 105 cycles after the previous acceptance.
REQ-025 SHALL register ps2_clk and ps2_data so that neither output glitches.
REQ-026 SHALL treat key_code 0x00 and 0xFF as ordinary bytes.

Reset
REQ-027 SHALL, while clrn=0, immediately force ps2_clk=1, ps2_data=1, frame_done=0, key_ready=0, state IDLE, and clear all counters.
REQ-028 SHALL drive key_ready=1 on the first clk edge after clrn deasserts.
REQ-029 SHALL discard a frame interrupted by reset mid-byte; it is never resumed or completed.

Configuration
REQ-030 SHALL, with PS2_SENDER_EXT_EN defined, send E0 ahead of the other bytes whenever key_ext=1 is accepted.
REQ-031 SHALL, without PS2_SENDER_EXT_EN, ignore key_ext and never emit E0.

Verification
REQ-032 SHALL cover a make event: key_code=0x1C, key_release=0 → one frame on the ps2_clk falling edges with sampled bits 0,0,0,1,1,1,0,0,0,0,1 and one frame_done pulse.
REQ-033 SHALL cover a break event: key_code=0x1C, key_release=1 → frame F0 (parity 1) then frame 1C (parity 0), two frame_done pulses, and key_ready=0 throughout.
REQ-034 SHALL cover an extended break with PS2_SENDER_EXT_EN defined: key_code=0x75, key_ext=1, key_release=1 → bytes E0, F0, 75; without the macro → bytes F0, 75 only.
REQ-035 SHALL cover timing with the default parameters: acceptance at cycle 10 → ps2_data falls at cycle 11, first ps2_clk falling edge at cycle 15, key_ready rises at cycle 115.
REQ-036 SHALL cover reset and drop behaviour:
  - pulse clrn=0 during DATA bit 4 → ps2_clk=1 and ps2_data=1 in the same cycle, no frame_done, and the next request 0x00 sends parity 1;
  - key_valid=1 held for the whole transfer → exactly one event is sent.
